// File: rtl/pwm_duty_decoder_if.sv
// pwm_duty_decoder_if: remote PWM line in, measured duty/period/scancode and status out
interface pwm_duty_decoder_if;
    logic       i_pwm_in;
    logic [9:0] o_duty;
    logic [9:0] o_period;
    logic [7:0] o_scancode;
    logic       o_valid;
    logic       o_locked;
    logic       o_lost;
    modport master (output i_pwm_in, input o_duty, o_period, o_scancode, o_valid, o_locked, o_lost);
    modport slave  (input i_pwm_in, output o_duty, o_period, o_scancode, o_valid, o_locked, o_lost);
endinterface

// File: rtl/pwm_duty_decoder.sv
// pwm_duty_decoder: samples a PWM line on the generator's tick grid, measures
// period/high time in ticks and maps the duty back to the selecting scancode.
module pwm_duty_decoder #(
    parameter int DIV1       = 25,
    parameter int DIV2       = 25,
    parameter int NOM_PERIOD = 801,
    parameter int TOL        = 2,
    parameter int TIMEOUT    = 1000
) (
    input  logic              reset,
    input  logic              clkdiv4,
    pwm_duty_decoder_if.slave bus
);
    typedef enum logic {IDLE, MEASURE} state_t;
    state_t     r_state, w_state;
    logic       r_s1, r_s, r_smp;
    logic [4:0] r_c1, r_c2;
    logic [9:0] r_pcnt, r_hcnt, w_pcnt, w_hcnt;
    logic [9:0] r_duty, r_period, w_duty, w_period;
    logic [7:0] r_code, w_code;
    logic       r_valid, r_locked, r_lost, w_valid, w_locked, w_lost;
    logic       w_c1_end, w_tick, w_rise;

    // distance computed by ordering so unsigned values never wrap
    function automatic logic near(input logic [9:0] a, input logic [9:0] b);
        return ((a > b) ? a - b : b - a) <= 10'(TOL);
    endfunction

    function automatic logic [7:0] classify(input logic [9:0] h);
        return near(h, 10'd41) ? 8'h2B :
               near(h, 10'd51) ? 8'h15 :
               near(h, 10'd61) ? 8'h33 :
               near(h, 10'd81) ? 8'h22 : 8'h00;
    endfunction

    assign w_c1_end = r_c1 == 5'(DIV1 - 1);
    assign w_tick   = w_c1_end && r_c2 == 5'(DIV2 - 1);
    assign w_rise   = w_tick && r_s && !r_smp;

    always_ff @(posedge clkdiv4 or posedge reset) begin
        if (reset) begin
            r_s1  <= 1'b0;
            r_s   <= 1'b0;
            r_smp <= 1'b0;
            r_c1  <= '0;
            r_c2  <= '0;
        end else begin
            r_s1 <= bus.i_pwm_in;
            r_s  <= r_s1;
            r_c1 <= w_c1_end ? '0 : r_c1 + 5'd1;
            if (w_c1_end)
                r_c2 <= (r_c2 == 5'(DIV2 - 1)) ? '0 : r_c2 + 5'd1;
            if (w_tick)
                r_smp <= r_s;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_pcnt   = r_pcnt;
        w_hcnt   = r_hcnt;
        w_duty   = r_duty;
        w_period = r_period;
        w_code   = r_code;
        w_valid  = 1'b0;
        w_locked = r_locked;
        w_lost   = r_lost;
        if (w_tick) begin
            if (w_rise) begin
                w_state = MEASURE;
                w_pcnt  = 10'd1;
                w_hcnt  = 10'd1;
                if (r_state == MEASURE) begin
                    w_period = r_pcnt;
                    w_duty   = r_hcnt;
                    w_code   = classify(r_hcnt);
                    w_locked = near(r_pcnt, 10'(NOM_PERIOD));
                    w_lost   = 1'b0;
                    w_valid  = 1'b1;
                end
            end else if (r_state == IDLE) begin
                w_pcnt = '0;
                w_hcnt = '0;
            end else if (r_pcnt == 10'(TIMEOUT)) begin
                w_state  = IDLE;
                w_lost   = 1'b1;
                w_locked = 1'b0;
                w_pcnt   = '0;
                w_hcnt   = '0;
            end else begin
                w_pcnt = r_pcnt + 10'd1;
                w_hcnt = (r_hcnt == 10'(TIMEOUT)) ? r_hcnt : r_hcnt + {9'd0, r_s};
            end
        end
    end

    always_ff @(posedge clkdiv4 or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_pcnt   <= '0;
            r_hcnt   <= '0;
            r_duty   <= '0;
            r_period <= '0;
            r_code   <= '0;
            r_valid  <= 1'b0;
            r_locked <= 1'b0;
            r_lost   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_pcnt   <= w_pcnt;
            r_hcnt   <= w_hcnt;
            r_duty   <= w_duty;
            r_period <= w_period;
            r_code   <= w_code;
            r_valid  <= w_valid;
            r_locked <= w_locked;
            r_lost   <= w_lost;
        end
    end

    assign bus.o_duty     = r_duty;
    assign bus.o_period   = r_period;
    assign bus.o_scancode = r_code;
    assign bus.o_valid    = r_valid;
    assign bus.o_locked   = r_locked;
    assign bus.o_lost     = r_lost;
endmodule

// File: tb/tb_pwm_duty_decoder.sv
// tb_pwm_duty_decoder: random and directed PWM streams checked every cycle
// against an edge/sample-history model, plus a default-prescaler instance.
module tb_pwm_duty_decoder;
    localparam int TIMEOUT = 1000, NOM = 801, TOL = 2;
    logic clk = 1'b0, rst = 1'b1, rst2 = 1'b1;
    int   n_chk = 0, n_fail = 0, n_valid = 0, cyc = 0, t_valid = 0, t_lost = 0;
    logic prev_v = 1'b0, prev_lost = 1'b0;

    always #5 clk = ~clk;

    pwm_duty_decoder_if bus();
    pwm_duty_decoder_if bus2();

    pwm_duty_decoder #(.DIV1(1), .DIV2(1), .NOM_PERIOD(NOM), .TOL(TOL), .TIMEOUT(TIMEOUT))
        dut (.reset(rst), .clkdiv4(clk), .bus(bus));
    pwm_duty_decoder dut2 (.reset(rst2), .clkdiv4(clk), .bus(bus2));

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // model: the sample seen on each tick is the input from two clocks earlier;
    // a measurement is the list of samples between consecutive rising edges
    logic       q1, q2, prv, s_now;
    bit         meas;
    bit         hist[$];
    int         ones;
    logic       m_valid, m_locked, m_lost;
    logic [9:0] m_duty, m_period;
    logic [7:0] m_code;

    function automatic logic [7:0] code_of(input int h);
        int         c[4] = '{41, 51, 61, 81};
        logic [7:0] k[4] = '{8'h2B, 8'h15, 8'h33, 8'h22};
        for (int i = 0; i < 4; i++)
            if (h >= c[i] - TOL && h <= c[i] + TOL) return k[i];
        return 8'h00;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            q1 = 0; q2 = 0; prv = 0; meas = 0; hist.delete();
            m_valid = 0; m_locked = 0; m_lost = 0; m_duty = 0; m_period = 0; m_code = 0;
        end else begin
            s_now = q2; q2 = q1; q1 = bus.i_pwm_in;
            m_valid = 0;
            if (s_now && !prv) begin
                if (meas) begin
                    ones = 0;
                    foreach (hist[i]) ones += int'(hist[i]);
                    m_valid  = 1;
                    m_period = 10'(hist.size());
                    m_duty   = 10'(ones);
                    m_code   = code_of(ones);
                    m_locked = hist.size() >= NOM - TOL && hist.size() <= NOM + TOL;
                    m_lost   = 0;
                end
                meas = 1;
                hist.delete();
                hist.push_back(1'b1);
            end else if (meas) begin
                if (hist.size() == TIMEOUT) begin
                    meas = 0; m_lost = 1; m_locked = 0; hist.delete();
                end else
                    hist.push_back(s_now);
            end
            prv = s_now;
        end
    end

    always @(posedge clk) begin
        #3;
        cyc++;
        check("cycle", {bus.o_valid, bus.o_locked, bus.o_lost, bus.o_scancode, bus.o_period, bus.o_duty},
                       {m_valid, m_locked, m_lost, m_code, m_period, m_duty});
        if (bus.o_valid) begin
            check("valid_gap", prev_v, 1'b0);
            n_valid++;
            t_valid = cyc;
        end
        if (bus.o_lost && !prev_lost) t_lost = cyc;
        prev_v = bus.o_valid;
        prev_lost = bus.o_lost;
    end

    task automatic run_pwm(input int high, input int per, input int n);
        for (int k = 0; k < n; k++)
            for (int i = 0; i < per; i++) begin
                @(negedge clk);
                bus.i_pwm_in = (i < high);
            end
    endtask

    task automatic expect_out(input string name, input int d, input int p, input int code, input int lk, input int ls);
        check({name, "_duty"}, bus.o_duty, 64'(d));
        check({name, "_period"}, bus.o_period, 64'(p));
        check({name, "_code"}, bus.o_scancode, 64'(code));
        check({name, "_locked"}, bus.o_locked, 64'(lk));
        check({name, "_lost"}, bus.o_lost, 64'(ls));
    endtask

    // default 625-cycle tick: input high at release, low at 700, high at 1300;
    // edges land on ticks 1 and 3, so the first valid shows after clock 1875
    task automatic dut2_run(output int vcyc);
        bit got = 0;
        vcyc = 0;
        bus2.i_pwm_in = 1'b1;
        @(negedge clk);
        rst2 = 1'b0;
        for (int c = 1; c <= 2500 && !got; c++) begin
            @(posedge clk);
            #3;
            if (bus2.o_valid) begin got = 1; vcyc = c; end
            if (c == 700) bus2.i_pwm_in = 1'b0;
            if (c == 1300) bus2.i_pwm_in = 1'b1;
        end
    endtask

    initial begin
        int v;
        int base[4] = '{41, 51, 61, 81};
        bus.i_pwm_in = 1'b0;
        bus2.i_pwm_in = 1'b0;
        repeat (3) @(negedge clk);
        expect_out("reset", 0, 0, 0, 0, 0);
        check("reset_valid", bus.o_valid, 1'b0);
        rst = 1'b0;

        run_pwm(41, 801, 3);
        expect_out("d41", 41, 801, 8'h2B, 1, 0);
        check("d41_nvalid", 64'(n_valid), 64'd2);
        check("model_d41", {m_code, m_duty}, {8'h2B, 10'd41});

        run_pwm(51, 801, 3);
        expect_out("d51", 51, 801, 8'h15, 1, 0);
        run_pwm(81, 801, 1);
        expect_out("sw_prev", 51, 801, 8'h15, 1, 0);
        run_pwm(81, 801, 1);
        expect_out("sw_81", 81, 801, 8'h22, 1, 0);

        run_pwm(43, 801, 2);
        expect_out("d43", 43, 801, 8'h2B, 1, 0);
        run_pwm(45, 801, 2);
        expect_out("d45", 45, 801, 8'h00, 1, 0);

        run_pwm(45, 300, 1);
        @(negedge clk);
        rst = 1'b1;
        bus.i_pwm_in = 1'b0;
        #1;
        expect_out("midrst", 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        run_pwm(61, 700, 2);
        expect_out("p700", 61, 700, 8'h33, 0, 0);
        check("model_p700", m_period, 10'd700);

        run_pwm(0, TIMEOUT + 50, 1);
        expect_out("stuck", 61, 700, 8'h33, 0, 1);
        check("lost_delay", 64'(t_lost - t_valid), 64'(TIMEOUT));
        run_pwm(41, 801, 2);
        expect_out("restart", 41, 801, 8'h2B, 1, 0);

        run_pwm(100, TIMEOUT, 3);
        expect_out("p_tmo", 100, TIMEOUT, 8'h00, 0, 0);
        run_pwm(100, TIMEOUT + 1, 3);
        expect_out("p_tmo1", 100, TIMEOUT, 8'h00, 0, 1);

        for (int it = 0; it < 12; it++) begin
            int h, p;
            if (it % 4 == 3) begin
                p = $urandom_range(2, 30);
                h = $urandom_range(1, p - 1);
            end else begin
                h = base[$urandom_range(0, 3)] + $urandom_range(0, 8) - 4;
                p = (it % 2 == 0) ? NOM + $urandom_range(0, 6) - 3 : $urandom_range(300, 990);
            end
            run_pwm(h, p, 2);
        end

        dut2_run(v);
        check("dut2_first_valid", 64'(v), 64'd1875);
        check("dut2_meas", {bus2.o_scancode, bus2.o_period, bus2.o_duty}, {8'h00, 10'd2, 10'd1});
        check("dut2_status", {bus2.o_locked, bus2.o_lost}, 2'b00);
        repeat (100) @(negedge clk);
        rst2 = 1'b1;
        #1;
        check("dut2_rst", {bus2.o_valid, bus2.o_locked, bus2.o_lost, bus2.o_scancode, bus2.o_period, bus2.o_duty}, 64'd0);
        repeat (3) @(negedge clk);
        dut2_run(v);
        check("dut2_again", 64'(v), 64'd1875);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
